dec_key_sched: RTL and testbench

AES-128 decryption round-key scheduler. It sits directly upstream of the decryption round stage and supplies that stage's keyin each round. It takes the cipher key, expands all 11 round keys iteratively (one per cycle) into a local key store, then streams them last-to-first (rk10 down to rk0) over a valid/ready handshake. A round controller consumes one key per round.

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_sbox.sv | 39 +++
 rtl/dec_key_sched.sv | 141 ++++++++++++++
 tb/tb_dec_key_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, Rcon table,
// scheduler state encoding and the round-key type.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    STREAM
  } ks_state_t;

  // Round constant for key-expansion step `round` (1..10); only the MSB byte is non-zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// followed by the FIPS-197 affine transform.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the inverse for x != 0 and yields 0 for x == 0, as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    b = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, b);
      b = gf_mul(b, b);
    end
    return r;
  endfunction

  logic [7:0] inv;

  assign inv = gf_inv(data);
  assign sub = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/dec_key_sched.sv
// AES-128 round-key scheduler: expands the cipher key one round per cycle
// into a local store, then streams the round keys over valid/ready.
module dec_key_sched
  import aes_pkg::*;
#(
  parameter int NR      = 10,
  parameter bit REVERSE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic         out_ready,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  if (NR != AES_NR) begin : g_nr_check
    $fatal(1, "dec_key_sched: only NR=10 (AES-128) is supported");
  end

  localparam logic [3:0] FIRST_IDX = REVERSE ? 4'd10 : 4'd0;
  localparam logic [3:0] LAST_IDX  = REVERSE ? 4'd0  : 4'd10;

  ks_state_t  state, state_d;
  logic [3:0] cnt, cnt_d;
  round_key_t key_out_d;
  logic       valid_d;
  logic [3:0] idx_d;
  logic       done_d;

  round_key_t rk_store [0:AES_NR];
  round_key_t last_rk;
  logic       store_we;
  logic [3:0] store_addr;
  round_key_t store_data;

  // One expansion step from the most recently written round key.
  logic [31:0] w0, w1, w2, w3, rot, sub_word, n0, n1, n2, n3;
  round_key_t  next_rk;

  assign {w0, w1, w2, w3} = last_rk;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .data (rot[8*g +: 8]),
      .sub  (sub_word[8*g +: 8])
    );
  end

  assign n0      = w0 ^ sub_word ^ {rcon(cnt), 24'h000000};
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  assign busy = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    key_out_d  = key_out;
    valid_d    = key_valid;
    idx_d      = round_idx;
    done_d     = 1'b0;
    store_we   = 1'b0;
    store_addr = cnt;
    store_data = next_rk;
    case (state)
      IDLE: begin
        if (key_load) begin
          state_d    = EXPAND;
          cnt_d      = 4'd1;
          store_we   = 1'b1;
          store_addr = 4'd0;
          store_data = key_in;
        end
      end
      EXPAND: begin
        store_we = 1'b1;
        cnt_d    = cnt + 4'd1;
        if (cnt == 4'(AES_NR)) begin
          // rk10 is not in the store until this edge, so forward it directly.
          state_d   = STREAM;
          cnt_d     = 4'd0;
          valid_d   = 1'b1;
          idx_d     = FIRST_IDX;
          key_out_d = REVERSE ? next_rk : rk_store[0];
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (round_idx == LAST_IDX) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            key_out_d = '0;
            idx_d     = 4'd0;
            done_d    = 1'b1;
          end else begin
            idx_d     = REVERSE ? round_idx - 4'd1 : round_idx + 4'd1;
            key_out_d = rk_store[idx_d];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      key_out   <= '0;
      key_valid <= 1'b0;
      round_idx <= 4'd0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      key_out   <= key_out_d;
      key_valid <= valid_d;
      round_idx <= idx_d;
      done      <= done_d;
    end
  end

  // NOTE: the key store is deliberately not reset; every load rewrites it before any read.
  always_ff @(posedge clk) begin
    if (store_we) begin
      rk_store[store_addr] <= store_data;
      last_rk              <= store_data;
    end
  end

endmodule

// File: tb/tb_dec_key_sched.sv
// Self-checking bench for dec_key_sched: FIPS-197 key schedules streamed
// in both orders, back-pressure, ignored loads, async reset and back-to-back.
module tb_dec_key_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] key_out;
  logic         key_valid;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  logic         key_load_f = 1'b0;
  logic         out_ready_f = 1'b0;
  logic [127:0] key_out_f;
  logic         key_valid_f;
  logic [3:0]   round_idx_f;
  logic         busy_f;
  logic         done_f;

  always #5 clk = ~clk;

  dec_key_sched #(.NR(10), .REVERSE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_load  (key_load),
    .out_ready (out_ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  dec_key_sched #(.NR(10), .REVERSE(1'b0)) dut_fwd (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_load  (key_load_f),
    .out_ready (out_ready_f),
    .key_out   (key_out_f),
    .key_valid (key_valid_f),
    .round_idx (round_idx_f),
    .busy      (busy_f),
    .done      (done_f)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2_KEY   = 128'h000102030405060708090a0b0c0d0e0f;

  // FIPS-197 Appendix A.1 and C.1 expanded round keys, rk0..rk10.
  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  logic [127:0] k2_rk [11] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
  } exp_t;

  typedef struct {
    bit           use_k2;
    bit           bp;
    bit           poke;
    logic [127:0] exp_first;
    logic [127:0] exp_last;
  } scen_t;

  exp_t         sb_q [$];
  exp_t         sb_e;
  int           n_pass = 0;
  int           n_total = 0;
  int           xfer_cnt = 0;
  logic [127:0] last_accepted = '0;
  bit           hold_pending = 1'b0;
  logic [127:0] held_key = '0;
  logic [3:0]   held_idx = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input bit use_k2);
    for (int i = 0; i < 11; i++) begin
      exp_t e;
      e.idx = 4'(10 - i);
      e.rk  = use_k2 ? k2_rk[10 - i] : fips_rk[10 - i];
      sb_q.push_back(e);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic run_to_done(input string name);
    int c;
    c = 0;
    out_ready = 1'b1;
    while (!done && c < 100) begin
      tick();
      c++;
    end
    out_ready = 1'b0;
    check(name, 128'(done), 128'(1));
  endtask

  // Scoreboard monitor: pops one expectation per transfer and checks stalls hold.
  always @(negedge clk) begin
    if (!rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("stall_key_stable", key_out, held_key);
        check("stall_idx_stable", 128'(round_idx), 128'(held_idx));
      end
      if (key_valid && out_ready) begin
        xfer_cnt++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_key", key_out, '0);
        end else begin
          sb_e = sb_q.pop_front();
          check("sb_key", key_out, sb_e.rk);
          check("sb_idx", 128'(round_idx), 128'(sb_e.idx));
          last_accepted = key_out;
        end
      end
      hold_pending = key_valid && !out_ready;
      held_key     = key_out;
      held_idx     = round_idx;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t scen [4];
    int    c;
    int    first_valid;
    bit    seen_done;

    scen[0] = '{use_k2: 1'b0, bp: 1'b0, poke: 1'b0,
                exp_first: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                exp_last:  128'h2b7e151628aed2a6abf7158809cf4f3c};
    scen[1] = '{use_k2: 1'b0, bp: 1'b1, poke: 1'b0,
                exp_first: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                exp_last:  128'h2b7e151628aed2a6abf7158809cf4f3c};
    scen[2] = '{use_k2: 1'b0, bp: 1'b0, poke: 1'b1,
                exp_first: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                exp_last:  128'h2b7e151628aed2a6abf7158809cf4f3c};
    scen[3] = '{use_k2: 1'b1, bp: 1'b0, poke: 1'b0,
                exp_first: 128'h13111d7fe3944a17f307a78b4d2b30c5,
                exp_last:  128'h000102030405060708090a0b0c0d0e0f};

    // Reset state, both while held and after release.
    #1;
    check("rst_key_out", key_out, '0);
    check("rst_valid", 128'(key_valid), 128'(0));
    check("rst_idx", 128'(round_idx), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("idle_valid", 128'(key_valid), 128'(0));
    check("idle_busy", 128'(busy), 128'(0));

    foreach (scen[s]) begin
      xfer_cnt = 0;
      push_stream(scen[s].use_k2);
      load_key(scen[s].use_k2 ? K2_KEY : FIPS_KEY);
      check("busy_after_load", 128'(busy), 128'(1));
      first_valid = -1;
      seen_done   = 1'b0;
      c = 0;
      while (!seen_done && c < 300) begin
        key_load = 1'b0;
        if (scen[s].poke && (c == 3 || c == 12)) begin
          key_in   = scen[s].use_k2 ? FIPS_KEY : K2_KEY;
          key_load = 1'b1;
        end
        out_ready = scen[s].bp ? (c % 3 == 0) : 1'b1;
        tick();
        c++;
        if (key_valid && first_valid < 0) begin
          first_valid = c;
          check("first_key", key_out, scen[s].exp_first);
          check("first_idx", 128'(round_idx), 128'(10));
        end
        if (done) seen_done = 1'b1;
      end
      key_load  = 1'b0;
      out_ready = 1'b0;
      check("first_valid_latency", 128'(first_valid), 128'(10));
      check("done_seen", 128'(seen_done), 128'(1));
      check("busy_at_done", 128'(busy), 128'(0));
      check("valid_at_done", 128'(key_valid), 128'(0));
      check("key_out_at_done", key_out, '0);
      check("last_key", last_accepted, scen[s].exp_last);
      tick();
      check("done_one_cycle", 128'(done), 128'(0));
      check("xfer_count", 128'(xfer_cnt), 128'(11));
      check("sb_drained", 128'(sb_q.size()), 128'(0));
      sb_q.delete();
    end

    // Back-to-back: load on the accepting edge is ignored, the next edge's load is taken.
    xfer_cnt = 0;
    push_stream(1'b0);
    load_key(FIPS_KEY);
    out_ready = 1'b1;
    c = 0;
    while (!(key_valid && round_idx == 4'd0) && c < 100) begin
      tick();
      c++;
    end
    check("b2b_last_pending", 128'(key_valid && round_idx == 4'd0), 128'(1));
    key_in   = K2_KEY;
    key_load = 1'b1;
    tick();
    check("b2b_done", 128'(done), 128'(1));
    check("b2b_busy_low", 128'(busy), 128'(0));
    push_stream(1'b1);
    tick();
    key_load = 1'b0;
    check("b2b_reload_busy", 128'(busy), 128'(1));
    check("b2b_reload_done_low", 128'(done), 128'(0));
    run_to_done("b2b_second_done");
    check("b2b_xfer_count", 128'(xfer_cnt), 128'(22));
    check("b2b_sb_drained", 128'(sb_q.size()), 128'(0));
    tick();

    // Async reset after four keys accepted, then a fresh load re-expands.
    xfer_cnt = 0;
    push_stream(1'b0);
    load_key(FIPS_KEY);
    out_ready = 1'b1;
    c = 0;
    while (!(key_valid && round_idx == 4'd6) && c < 100) begin
      tick();
      c++;
    end
    check("mid_accepted_four", 128'(xfer_cnt), 128'(4));
    #2 rst = 1'b0;
    #1;
    check("arst_key_out", key_out, '0);
    check("arst_valid", 128'(key_valid), 128'(0));
    check("arst_idx", 128'(round_idx), 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
    out_ready = 1'b0;
    sb_q.delete();
    tick();
    rst = 1'b1;
    tick();
    xfer_cnt = 0;
    push_stream(1'b1);
    load_key(K2_KEY);
    c = 0;
    while (!key_valid && c < 50) begin
      tick();
      c++;
    end
    check("reload_first_key", key_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    run_to_done("reload_done");
    check("reload_xfer_count", 128'(xfer_cnt), 128'(11));
    check("reload_sb_drained", 128'(sb_q.size()), 128'(0));

    // Encrypt-order instance streams rk0..rk10.
    key_in     = FIPS_KEY;
    key_load_f = 1'b1;
    tick();
    key_load_f  = 1'b0;
    out_ready_f = 1'b1;
    c = 0;
    while (!key_valid_f && c < 50) begin
      tick();
      c++;
    end
    check("fwd_latency", 128'(c), 128'(10));
    for (int i = 0; i < 11; i++) begin
      check("fwd_key", key_out_f, fips_rk[i]);
      check("fwd_idx", 128'(round_idx_f), 128'(i));
      tick();
    end
    check("fwd_done", 128'(done_f), 128'(1));
    check("fwd_busy_low", 128'(busy_f), 128'(0));
    out_ready_f = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
